rr_onehot_arbiter: RTL and testbench



---
 rtl/rr_onehot_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// Four-way round-robin arbiter producing a registered one-hot mux select.
// Grants persist until release, request drop or hold-time limit; handovers are back-to-back.
//
// state | meaning
// IDLE  | no grant active, outputs zero, arbitrate on any request
// BUSY  | one source granted, hold counter running
module rr_onehot_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req_i,
    input  logic             release_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       hold_q, hold_d;

    logic [N-1:0]     rem;
    logic [IDX_W-1:0] pick_req, pick_rem;
    logic             hold_at_max;
    logic             grant_end;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'((int'(i) + 1) % N);
    endfunction

    // First set bit of v searching upward from p with wraparound.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] v,
                                              input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] k;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int o = 0; o < N; o++) begin
            k = IDX_W'((int'(p) + o) % N);
            if (!found && v[k]) begin
                r     = k;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign rem         = req_i & ~gnt_q;
    assign pick_req    = pick(req_i, ptr_q);
    assign pick_rem    = pick(rem, ptr_q);
    assign hold_at_max = (hold_q >= 8'(MAX_HOLD));
    assign grant_end   = release_i | ~req_i[idx_q] | hold_at_max;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    gnt_d   = N'(1) << pick_req;
                    idx_d   = pick_req;
                    ptr_d   = next_idx(pick_req);
                    hold_d  = 8'd1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!grant_end) begin
                    hold_d = hold_q + 8'd1;
                end else if (|rem) begin
                    gnt_d  = N'(1) << pick_rem;
                    idx_d  = pick_rem;
                    ptr_d  = next_idx(pick_rem);
                    hold_d = 8'd1;
                end else if (!release_i && req_i[idx_q]) begin
                    // Timeout with the grantee as sole requester: restart its hold window.
                    ptr_d  = next_idx(idx_q);
                    hold_d = 8'd1;
                end else begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    hold_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                idx_d   = '0;
                hold_d  = 8'd0;
                ptr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = valid_q;
    assign gnt_idx_o   = idx_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed literal sequences plus randomized traffic
// compared every cycle against an integer-level round-robin model.
module tb_rr_onehot_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] idx;

    int asserts = 0;
    int fails   = 0;

    // model: granted index (-1 = none), pointer, cycles held
    int m_idx  = -1;
    int m_ptr  = 0;
    int m_hold = 0;

    rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_i      (req),
        .release_i  (rel),
        .gnt_o      (gnt),
        .gnt_valid_o(valid),
        .gnt_idx_o  (idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pickm(input logic [3:0] v, input int p);
        logic [1:0] k;
        for (int o = 0; o < N; o++) begin
            k = 2'((p + o) % N);
            if (v[k]) return int'(k);
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int   k;
        logic drop, tmo;
        if (!reset_n) begin
            m_idx  = -1;
            m_ptr  = 0;
            m_hold = 0;
        end else if (m_idx < 0) begin
            k = pickm(req, m_ptr);
            if (k >= 0) begin
                m_idx = k; m_hold = 1; m_ptr = (k + 1) % N;
            end
        end else begin
            drop = !req[2'(m_idx)];
            tmo  = (m_hold == MAX_HOLD);
            if (!(rel || drop || tmo)) begin
                m_hold++;
            end else begin
                k = pickm(req & ~(4'(1) << m_idx), m_ptr);
                if (k >= 0) begin
                    m_idx = k; m_hold = 1; m_ptr = (k + 1) % N;
                end else if (!rel && !drop) begin
                    m_hold = 1; m_ptr = (m_idx + 1) % N;
                end else begin
                    m_idx = -1; m_hold = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        eg = (m_idx < 0) ? 4'b0000 : (4'(1) << m_idx);
        check("model_gnt", 32'(gnt), 32'(eg));
        check("model_valid", 32'(valid), 32'(m_idx >= 0));
        check("model_idx", 32'(idx), 32'((m_idx < 0) ? 0 : m_idx));
    end

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0; req = 4'b0000; rel = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_b [10];
        logic [3:0] exp_d;
        reset_n = 1'b0;
        req     = 4'b0000;
        rel     = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;

        // idle with no requests
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_valid", 32'(valid), 32'h0);
            check("idle_idx", 32'(idx), 32'h0);
        end

        // all requesting, release every second cycle
        exp_b = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        do_reset();
        req = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("rr_release_gnt", 32'(gnt), 32'(exp_b[i-1]));
            #1 rel = (i % 2 == 0);
        end

        // sole requester re-granted across timeouts, pointer lands on 3
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("sole_gnt", 32'(gnt), 32'h4);
        end
        #1 rel = 1'b1; req = 4'b1111;
        @(negedge clk);
        check("ptr_after_sole", 32'(gnt), 32'h8);
        #1 rel = 1'b0;

        // two requesters alternate on timeout
        do_reset();
        req = 4'b0101;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            exp_d = (i <= 8 || i > 16) ? 4'b0001 : 4'b0100;
            check("timeout_rotate", 32'(gnt), 32'(exp_d));
        end

        // drop to idle, new request, then asynchronous reset mid-grant
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        check("drop_start", 32'(gnt), 32'h2);
        #1 req = 4'b0000;
        @(negedge clk);
        check("drop_idle", 32'(gnt), 32'h0);
        check("drop_idle_valid", 32'(valid), 32'h0);
        #1 req = 4'b1000;
        @(negedge clk);
        check("new_req", 32'(gnt), 32'h8);
        check("new_req_idx", 32'(idx), 32'h3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_valid", 32'(valid), 32'h0);
        #1 reset_n = 1'b1; req = 4'b1111;
        @(negedge clk);
        check("post_rst_ptr0", 32'(gnt), 32'h1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 4'b1111;
                    1:       req = 4'b0000;
                    default: req = 4'($urandom);
                endcase
            end
            rel = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
